// File: rtl/section_min_max_collector_pkg.sv
// Shared level-meter package.
// Holds the default sample width, the accumulator seed constants and the
// unsigned min/max select helpers. The section min/max buffer reuses the
// same helpers, so both blocks agree on how two levels are ordered.
package section_min_max_collector_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Widest level any user of this package may instantiate. Callers
  // zero-extend into level_t and size-cast the result back. Zero
  // extension preserves unsigned ordering, so the select stays exact.
  localparam int MAX_LEVEL_WIDTH = 64;
  typedef logic [MAX_LEVEL_WIDTH-1:0] level_t;

  // Accumulator seeds: a running minimum starts at all-ones and a running
  // maximum starts at zero. A size cast to the user's width keeps all-ones.
  localparam level_t MIN_INIT = '1;
  localparam level_t MAX_INIT = '0;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } collector_state_e;

  function automatic level_t min_sel(input level_t a, input level_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic level_t max_sel(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/section_min_max_collector_if.sv
// Handshake bundle of the section min/max collector.
// Sample side : i_valid, i_value in; i_ready back to the producer.
// Result side : o_valid, o_min_value, o_max_value out; o_ready in.
// slave  - the collector itself.
// master - whatever drives samples in and drains results.
interface section_min_max_collector_if
  import section_min_max_collector_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             i_valid;
  logic             i_ready;
  logic [WIDTH-1:0] i_value;
  logic             o_valid;
  logic             o_ready;
  logic [WIDTH-1:0] o_min_value;
  logic [WIDTH-1:0] o_max_value;

  modport slave (
    input  i_valid, i_value, o_ready,
    output i_ready, o_valid, o_min_value, o_max_value
  );

  modport master (
    output i_valid, i_value, o_ready,
    input  i_ready, o_valid, o_min_value, o_max_value
  );

endinterface

// File: rtl/section_min_max_collector.sv
// Section min/max collector.
// This block splits an unsigned sample stream into sections of
// SECTION_LENGTH samples. It emits one (min, max) pair per section.
// Ports:
//   clk   - single clock; all state changes on the rising edge.
//   reset - synchronous, active-high.
//   bus   - slave side of section_min_max_collector_if. It carries the
//           sample handshake (i_valid/i_ready/i_value) and the result
//           handshake (o_valid/o_ready/o_min_value/o_max_value).
//           i_ready and o_valid are registered.
// A finished section loads the output register directly if that register
// is free or draining. Otherwise it is parked in the accumulators (HOLD)
// and the input is throttled. At most two results are outstanding.
module section_min_max_collector
  import section_min_max_collector_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int SECTION_LENGTH = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  section_min_max_collector_if.slave   bus
);

  localparam int CW = (SECTION_LENGTH > 1) ? $clog2(SECTION_LENGTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(SECTION_LENGTH - 1);

  collector_state_e state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] acc_min_q, acc_min_d;
  logic [WIDTH-1:0] acc_max_q, acc_max_d;
  logic             i_ready_q, i_ready_d;
  logic             o_valid_q, o_valid_d;
  logic [WIDTH-1:0] o_min_q, o_min_d;
  logic [WIDTH-1:0] o_max_q, o_max_d;

  logic             in_hs;
  logic             out_hs;
  logic [WIDTH-1:0] new_min;
  logic [WIDTH-1:0] new_max;

  assign in_hs  = bus.i_valid && i_ready_q;
  assign out_hs = o_valid_q && bus.o_ready;

  // The first sample of a section seeds both extremes. This lets a
  // section start fresh without depending on the accumulator contents.
  always_comb begin
    if (count_q == '0) begin
      new_min = bus.i_value;
      new_max = bus.i_value;
    end else begin
      new_min = WIDTH'(min_sel(level_t'(acc_min_q), level_t'(bus.i_value)));
      new_max = WIDTH'(max_sel(level_t'(acc_max_q), level_t'(bus.i_value)));
    end
  end

  // NOTE: every signal this block drives gets a hold-value default first.
  // Then no path through the case leaves one unassigned, and no latch is
  // inferred.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    i_ready_d = i_ready_q;
    o_valid_d = o_valid_q;
    o_min_d   = o_min_q;
    o_max_d   = o_max_q;

    unique case (state_q)
      ACCUM: begin
        if (out_hs) o_valid_d = 1'b0;
        if (in_hs) begin
          if (count_q != LAST) begin
            count_d   = count_q + CW'(1);
            acc_min_d = new_min;
            acc_max_d = new_max;
          end else begin
            count_d = '0;
            if (!o_valid_q || out_hs) begin
              // Completion coincides with a free or draining output.
              // Stream straight through, with no bubble.
              o_min_d   = new_min;
              o_max_d   = new_max;
              o_valid_d = 1'b1;
              acc_min_d = WIDTH'(MIN_INIT);
              acc_max_d = WIDTH'(MAX_INIT);
            end else begin
              // Output still occupied: park the result and stop accepting.
              acc_min_d = new_min;
              acc_max_d = new_max;
              i_ready_d = 1'b0;
              state_d   = HOLD;
            end
          end
        end
      end

      HOLD: begin
        // i_ready_q is already 0, so no sample can arrive here.
        if (out_hs) begin
          o_min_d   = acc_min_q;
          o_max_d   = acc_max_q;
          o_valid_d = 1'b1;
          i_ready_d = 1'b1;
          acc_min_d = WIDTH'(MIN_INIT);
          acc_max_d = WIDTH'(MAX_INIT);
          state_d   = ACCUM;
        end
      end

      default: state_d = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Then every
  // register samples its _d value from before the edge, whatever the
  // statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      count_q   <= '0;
      acc_min_q <= WIDTH'(MIN_INIT);
      acc_max_q <= WIDTH'(MAX_INIT);
      i_ready_q <= 1'b1;
      o_valid_q <= 1'b0;
      o_min_q   <= '0;
      o_max_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      i_ready_q <= i_ready_d;
      o_valid_q <= o_valid_d;
      o_min_q   <= o_min_d;
      o_max_q   <= o_max_d;
    end
  end

  assign bus.i_ready     = i_ready_q;
  assign bus.o_valid     = o_valid_q;
  assign bus.o_min_value = o_min_q;
  assign bus.o_max_value = o_max_q;

endmodule

// File: tb/tb_section_min_max_collector.sv
// Directed bench for section_min_max_collector.
// Two instances are driven in lockstep:
//   dut4 - SECTION_LENGTH = 4
//   dut1 - SECTION_LENGTH = 1
// Inputs change 1 ns after the rising edge, and outputs are sampled there.
// Each sampled value is therefore the state left by the preceding edge.
module tb_section_min_max_collector;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  section_min_max_collector_if #(.WIDTH(16)) bus4 ();
  section_min_max_collector_if #(.WIDTH(16)) bus1 ();

  section_min_max_collector #(.WIDTH(16), .SECTION_LENGTH(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  section_min_max_collector #(.WIDTH(16), .SECTION_LENGTH(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one sample to dut4 for exactly one edge. i_ready is checked
  // first, because the sample is only taken if it is high.
  task automatic feed4(input logic [15:0] v, input string tag);
    check({tag, " i_ready"}, 32'(bus4.i_ready), 32'd1);
    bus4.i_valid = 1'b1;
    bus4.i_value = v;
    tick();
    bus4.i_valid = 1'b0;
  endtask

  task automatic expect4(input string tag, input logic v, input logic [15:0] mn, input logic [15:0] mx);
    check({tag, " o_valid"}, 32'(bus4.o_valid), 32'(v));
    check({tag, " o_min"},   32'(bus4.o_min_value), 32'(mn));
    check({tag, " o_max"},   32'(bus4.o_max_value), 32'(mx));
  endtask

  initial begin
    logic [15:0] v;
    int          results;
    int          ready_drops;
    int          sec;

    reset         = 1'b1;
    bus4.i_valid  = 1'b0;
    bus4.i_value  = '0;
    bus4.o_ready  = 1'b1;
    bus1.i_valid  = 1'b0;
    bus1.i_value  = '0;
    bus1.o_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state of both instances.
    check("rst4 i_ready", 32'(bus4.i_ready), 32'd1);
    expect4("rst4", 1'b0, 16'd0, 16'd0);
    check("rst1 i_ready", 32'(bus1.i_ready), 32'd1);
    check("rst1 o_valid", 32'(bus1.o_valid), 32'd0);

    // Basic section with o_ready held high.
    feed4(16'd100, "t1 s0");
    feed4(16'd5,   "t1 s1");
    feed4(16'd300, "t1 s2");
    check("t1 pre o_valid", 32'(bus4.o_valid), 32'd0);
    feed4(16'd42,  "t1 s3");
    expect4("t1 result", 1'b1, 16'd5, 16'd300);
    check("t1 i_ready", 32'(bus4.i_ready), 32'd1);
    tick();
    check("t1 one-cycle o_valid", 32'(bus4.o_valid), 32'd0);

    // Extremes, then a constant section that must not inherit them.
    feed4(16'h0000, "t2 s0");
    feed4(16'hFFFF, "t2 s1");
    feed4(16'h8000, "t2 s2");
    feed4(16'h7FFF, "t2 s3");
    expect4("t2 extremes", 1'b1, 16'h0000, 16'hFFFF);
    for (int i = 0; i < 4; i++) feed4(16'd7, "t2 sevens");
    expect4("t2 fresh seed", 1'b1, 16'd7, 16'd7);
    tick();

    // Backpressure: two sections with the output stalled.
    bus4.o_ready = 1'b0;
    for (int i = 1; i <= 4; i++) feed4(16'(i), "t3 a");
    expect4("t3 r1 loaded", 1'b1, 16'd1, 16'd4);
    for (int i = 10; i <= 13; i++) feed4(16'(i), "t3 b");
    expect4("t3 r1 stable", 1'b1, 16'd1, 16'd4);
    check("t3 i_ready drop", 32'(bus4.i_ready), 32'd0);
    tick();
    expect4("t3 r1 still stable", 1'b1, 16'd1, 16'd4);
    check("t3 i_ready held low", 32'(bus4.i_ready), 32'd0);
    bus4.o_ready = 1'b1;
    tick();
    expect4("t3 r2", 1'b1, 16'd10, 16'd13);
    check("t3 i_ready back", 32'(bus4.i_ready), 32'd1);
    tick();
    check("t3 drained", 32'(bus4.o_valid), 32'd0);

    // Continuous stream for 64 cycles. Section j uses the samples
    // 100j + {2,0,3,1}, so its result must be min=100j and max=100j+3.
    results     = 0;
    ready_drops = 0;
    bus4.i_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      case (k % 4)
        0:       v = 16'(100 * (k / 4) + 2);
        1:       v = 16'(100 * (k / 4));
        2:       v = 16'(100 * (k / 4) + 3);
        default: v = 16'(100 * (k / 4) + 1);
      endcase
      if (!bus4.i_ready) ready_drops++;
      bus4.i_value = v;
      tick();
      if (bus4.o_valid) begin
        sec = results;
        check("t4 cadence", 32'(k % 4), 32'd3);
        check("t4 min", 32'(bus4.o_min_value), 32'(100 * sec));
        check("t4 max", 32'(bus4.o_max_value), 32'(100 * sec + 3));
        results++;
      end
    end
    bus4.i_valid = 1'b0;
    check("t4 result count", 32'(results), 32'd16);
    check("t4 i_ready drops", 32'(ready_drops), 32'd0);
    tick();

    // Reset in the middle of a section. The partial data must be
    // discarded.
    feed4(16'd50, "t5 s0");
    feed4(16'd60, "t5 s1");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5 rst i_ready", 32'(bus4.i_ready), 32'd1);
    expect4("t5 rst", 1'b0, 16'd0, 16'd0);
    feed4(16'd9, "t5 s2");
    feed4(16'd3, "t5 s3");
    check("t5 no early result", 32'(bus4.o_valid), 32'd0);
    feed4(16'd8, "t5 s4");
    feed4(16'd4, "t5 s5");
    expect4("t5 result", 1'b1, 16'd3, 16'd9);
    tick();

    // SECTION_LENGTH = 1: each accepted sample is its own section.
    check("t6 i_ready", 32'(bus1.i_ready), 32'd1);
    bus1.i_valid = 1'b1;
    bus1.i_value = 16'd17;
    tick();
    check("t6 r0 o_valid", 32'(bus1.o_valid), 32'd1);
    check("t6 r0 min", 32'(bus1.o_min_value), 32'd17);
    check("t6 r0 max", 32'(bus1.o_max_value), 32'd17);
    bus1.i_value = 16'd2;
    tick();
    bus1.i_valid = 1'b0;
    check("t6 r1 o_valid", 32'(bus1.o_valid), 32'd1);
    check("t6 r1 min", 32'(bus1.o_min_value), 32'd2);
    check("t6 r1 max", 32'(bus1.o_max_value), 32'd2);
    check("t6 r1 i_ready", 32'(bus1.i_ready), 32'd1);
    tick();
    check("t6 drained", 32'(bus1.o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
